// File: rtl/obj_pkg.sv
// rtl/obj_pkg.sv - shared constants, object word fields, list entry and FSM types for obj_line_scan
package obj_pkg;

    localparam int OBJ_MAX_DEF  = 64;
    localparam int LINE_MAX_DEF = 8;
    localparam int OBJ_H_DEF    = 16;

    localparam int OBJ_W     = 29;
    localparam int X_LSB     = 0;
    localparam int Y_LSB     = 8;
    localparam int CODE_LSB  = 16;
    localparam int COL_LSB   = 24;
    localparam int FLIPH_BIT = 27;
    localparam int FLIPV_BIT = 28;

    typedef struct packed {
        logic [3:0]       row;
        logic [OBJ_W-1:0] word;
    } lst_entry_t;

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } scan_state_t;

endpackage

// File: rtl/obj_line_fifo.sv
// rtl/obj_line_fifo.sv - small synchronous FIFO holding the objects selected for the next line
module obj_line_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 33,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign push_ok = push & (count != CNT_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // Head reads as zero when empty so the output is clean after reset or clear
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/obj_line_scan.sv
// rtl/obj_line_scan.sv - object table capture and per-line hit scan; OBJ_LINE_OVF_EN enables overflow detection
module obj_line_scan
    import obj_pkg::*;
#(
    parameter int OBJ_MAX  = OBJ_MAX_DEF,
    parameter int LINE_MAX = LINE_MAX_DEF,
    parameter int OBJ_H    = OBJ_H_DEF
) (
    input  logic        CLK20,
    input  logic        RESET,
    input  logic        DMCS,
    input  logic [28:0] DO,
    input  logic [7:0]  V,
    input  logic        HBDn,
    input  logic        VB,
    input  logic        LST_RD,
    output logic [32:0] LST_DATA,
    output logic        LST_EMPTY,
    output logic [3:0]  LST_CNT,
    output logic        LST_RDY,
    output logic        OVF
);
    localparam int AW = $clog2(OBJ_MAX);
    localparam int CW = $clog2(OBJ_MAX + 1);

    logic [OBJ_W-1:0] obj_table [OBJ_MAX];
    logic [CW-1:0]    obj_cnt;
    logic [CW-1:0]    rd_idx;
    logic [AW-1:0]    wr_idx;
    logic             vb_q, hbdn_q;
    logic             vb_rise, hb_fall, hb_rise, wr_en;
    logic [7:0]       tgt, d;
    logic [OBJ_W-1:0] word_rd;
    logic [3:0]       row;
    logic             hit;
    logic             start, finish, push, rd_adv, pop, fifo_empty, lst_rdy;
    lst_entry_t       push_data;
    scan_state_t      state, state_nxt;
`ifdef OBJ_LINE_OVF_EN
    logic             ovf_set;
    logic             ovf;
`endif

    assign vb_rise = VB & ~vb_q;
    assign hb_fall = hbdn_q & ~HBDn;
    assign hb_rise = HBDn & ~hbdn_q;
    // A write coinciding with the VB edge lands at entry 0 of the new frame
    assign wr_en   = DMCS & (vb_rise | (obj_cnt != CW'(OBJ_MAX)));
    assign wr_idx  = vb_rise ? '0 : obj_cnt[AW-1:0];

    always_ff @(posedge CLK20) begin
        if (wr_en) begin
            obj_table[wr_idx] <= DO;
        end
    end

    always_ff @(posedge CLK20) begin
        if (RESET) begin
            vb_q    <= 1'b0;
            hbdn_q  <= 1'b1;
            obj_cnt <= '0;
        end else begin
            vb_q   <= VB;
            hbdn_q <= HBDn;
            if (vb_rise)    obj_cnt <= wr_en ? CW'(1) : '0;
            else if (wr_en) obj_cnt <= obj_cnt + CW'(1);
        end
    end

    assign word_rd   = obj_table[rd_idx[AW-1:0]];
    assign d         = tgt - word_rd[Y_LSB +: 8];
    assign hit       = (d < 8'(OBJ_H));
    assign row       = word_rd[FLIPV_BIT] ? ~d[3:0] : d[3:0];
    assign push_data = '{row: row, word: word_rd};

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        push      = 1'b0;
        rd_adv    = 1'b0;
`ifdef OBJ_LINE_OVF_EN
        ovf_set   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (hb_fall && !VB) begin
                    start = 1'b1;
                    if (obj_cnt == '0) finish    = 1'b1;
                    else               state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (hb_rise) begin
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wr_en) begin
                    state_nxt = S_SCAN;
                end else if (rd_idx >= obj_cnt) begin
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    rd_adv = 1'b1;
                    if ((rd_idx + CW'(1)) >= obj_cnt) begin
                        finish    = 1'b1;
                        state_nxt = S_IDLE;
                    end
                    if (hit) begin
                        if (LST_CNT < 4'(LINE_MAX)) push = 1'b1;
`ifdef OBJ_LINE_OVF_EN
                        else begin
                            ovf_set   = 1'b1;
                            finish    = 1'b1;
                            state_nxt = S_IDLE;
                        end
`else
                        if (LST_CNT == 4'(LINE_MAX - 1)) begin
                            finish    = 1'b1;
                            state_nxt = S_IDLE;
                        end
`endif
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK20) begin
        if (RESET) begin
            state   <= S_IDLE;
            rd_idx  <= '0;
            tgt     <= '0;
            lst_rdy <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                tgt     <= V + 8'd1;
                rd_idx  <= '0;
                lst_rdy <= 1'b0;
            end else if (rd_adv) begin
                rd_idx <= rd_idx + CW'(1);
            end
            if (finish) lst_rdy <= 1'b1;
        end
    end

`ifdef OBJ_LINE_OVF_EN
    always_ff @(posedge CLK20) begin
        if (RESET || start) ovf <= 1'b0;
        else if (ovf_set)   ovf <= 1'b1;
    end
    assign OVF = ovf;
`else
    assign OVF = 1'b0;
`endif

    assign LST_EMPTY = fifo_empty | (state == S_SCAN);
    assign pop       = LST_RD & ~LST_EMPTY;
    assign LST_RDY   = lst_rdy;

    obj_line_fifo #(
        .DEPTH (LINE_MAX),
        .WIDTH ($bits(lst_entry_t)),
        .CNT_W (4)
    ) u_fifo (
        .clk   (CLK20),
        .rst   (RESET),
        .clr   (start),
        .push  (push),
        .pop   (pop),
        .wdata (push_data),
        .rdata (LST_DATA),
        .count (LST_CNT),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_obj_line_scan.sv
// tb/tb_obj_line_scan.sv - randomized scoreboard bench for obj_line_scan against a line-hit reference model
module tb_obj_line_scan;

`ifdef OBJ_LINE_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        CLK20 = 1'b0;
    logic        RESET, DMCS, HBDn, VB, LST_RD;
    logic [28:0] DO;
    logic [7:0]  V;
    logic [32:0] LST_DATA;
    logic        LST_EMPTY, LST_RDY, OVF;
    logic [3:0]  LST_CNT;

    int          checks = 0;
    int          fails  = 0;
    logic [28:0] tbl[$];
    logic [28:0] wq[$];
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    always #5 CLK20 = ~CLK20;

    obj_line_scan dut (
        .CLK20     (CLK20),
        .RESET     (RESET),
        .DMCS      (DMCS),
        .DO        (DO),
        .V         (V),
        .HBDn      (HBDn),
        .VB        (VB),
        .LST_RD    (LST_RD),
        .LST_DATA  (LST_DATA),
        .LST_EMPTY (LST_EMPTY),
        .LST_CNT   (LST_CNT),
        .LST_RDY   (LST_RDY),
        .OVF       (OVF)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge CLK20) begin
        if (!RESET && LST_RD && !LST_EMPTY) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got entry 0x%0h expected none", LST_DATA);
            end else begin
                mon_e = exp_q.pop_front();
                checks--;
                chk("lst_data", LST_DATA, mon_e);
            end
        end
    end

    task automatic write_table();
        @(posedge CLK20); #1 VB = 1'b1;
        tbl.delete();
        foreach (wq[i]) begin
            @(posedge CLK20); #1 DMCS = 1'b1; DO = wq[i];
            if (tbl.size() < 64) tbl.push_back(wq[i]);
        end
        @(posedge CLK20); #1 DMCS = 1'b0; VB = 1'b0;
        wq.delete();
    endtask

    task automatic run_line(input logic [7:0] v, input int abort_at, input logic rd_hold, input string name);
        logic [7:0] tgt8, d8;
        logic [3:0] row;
        int         hits = 0, compares = 0, lat, k = 0;
        bit         ovf = 0, aborted = 0;
        tgt8 = v + 8'd1;
        for (int i = 0; i < tbl.size(); i++) begin
            if (abort_at > 0 && i == abort_at - 1) begin aborted = 1; break; end
            compares++;
            d8 = tgt8 - tbl[i][15:8];
            if (d8 < 8'd16) begin
                if (hits < 8) begin
                    row = tbl[i][28] ? (4'd15 - d8[3:0]) : d8[3:0];
                    exp_q.push_back({row, tbl[i]});
                    hits++;
                    if (!OVF_EN && hits == 8) break;
                end else begin
                    ovf = 1;
                    break;
                end
            end
        end
        lat = aborted ? abort_at + 1 : compares + 1;

        @(posedge CLK20); #1 V = v; HBDn = 1'b0; LST_RD = rd_hold;
        for (int c = 1; c <= 200; c++) begin
            @(posedge CLK20); #1;
            if (c == abort_at) HBDn = 1'b1;
            @(negedge CLK20);
            if (LST_RDY) begin k = c; break; end
        end
        chk({name, "_rdy_latency"}, k, lat);
        chk({name, "_cnt"}, LST_CNT, hits);
        chk({name, "_ovf"}, OVF, ovf);

        @(posedge CLK20); #1 HBDn = 1'b1; LST_RD = 1'b1;
        repeat (hits + 2) @(posedge CLK20);
        #1 LST_RD = 1'b0;
        @(negedge CLK20);
        chk({name, "_drained_cnt"}, LST_CNT, 0);
        chk({name, "_drained_empty"}, LST_EMPTY, 1);
        chk({name, "_scoreboard_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic logic [28:0] mk(input logic [7:0] y, input logic flipv, input logic [7:0] x);
        logic [28:0] w;
        w       = 29'($urandom);
        w[7:0]  = x;
        w[15:8] = y;
        w[28]   = flipv;
        return w;
    endfunction

    initial begin
        logic [7:0] v;
        int         n, ab;
        RESET = 1'b1; DMCS = 1'b0; DO = '0; V = '0; HBDn = 1'b1; VB = 1'b0; LST_RD = 1'b0;
        repeat (3) @(posedge CLK20);
        #1 RESET = 1'b0;
        @(negedge CLK20);
        chk("reset_empty", LST_EMPTY, 1);
        chk("reset_cnt", LST_CNT, 0);
        chk("reset_rdy", LST_RDY, 0);
        chk("reset_ovf", OVF, 0);
        chk("reset_data", LST_DATA, 0);

        wq.push_back(mk(8'h10, 1'b0, 8'h01));
        wq.push_back(mk(8'h20, 1'b0, 8'h02));
        wq.push_back(mk(8'h30, 1'b0, 8'h03));
        write_table();
        run_line(8'h14, 0, 1'b0, "basic3");

        wq.push_back(mk(8'hF8, 1'b1, 8'h44));
        write_table();
        run_line(8'h01, 0, 1'b0, "wrap_flipv");

        for (int i = 0; i < 10; i++) wq.push_back(mk(8'h40, i[0], 8'(i)));
        write_table();
        run_line(8'h40, 0, 1'b1, "ten_hits");

        for (int i = 0; i < 70; i++) wq.push_back(mk((i < 64) ? 8'h90 : 8'h21, 1'b0, 8'(i)));
        write_table();
        run_line(8'h20, 0, 1'b0, "table_full");

        for (int i = 0; i < 20; i++) wq.push_back(mk(8'h51 - 8'(i % 16), 1'b0, 8'(i)));
        write_table();
        run_line(8'h50, 3, 1'b0, "abort");

        write_table();
        run_line(8'h50, 2, 1'b0, "abort_refill");

        @(posedge CLK20); #1 V = 8'h50; HBDn = 1'b0; LST_RD = 1'b1;
        repeat (3) @(posedge CLK20);
        #1 RESET = 1'b1;
        @(posedge CLK20); #1 RESET = 1'b0; HBDn = 1'b1; LST_RD = 1'b0;
        @(negedge CLK20);
        chk("midscan_reset_empty", LST_EMPTY, 1);
        chk("midscan_reset_cnt", LST_CNT, 0);
        chk("midscan_reset_rdy", LST_RDY, 0);
        chk("midscan_reset_ovf", OVF, 0);
        chk("midscan_reset_data", LST_DATA, 0);
        tbl.delete();
        run_line(8'h50, 0, 1'b1, "after_reset_empty");

        for (int r = 0; r < 30; r++) begin
            v = 8'($urandom);
            n = $urandom_range(0, 24);
            for (int i = 0; i < n; i++)
                wq.push_back(mk(v + 8'd1 - 8'($urandom_range(0, 30)), 1'($urandom), 8'($urandom)));
            write_table();
            ab = ($urandom_range(0, 3) == 0 && n > 2) ? $urandom_range(2, n) : 0;
            run_line(v, ab, 1'($urandom), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
